// File: rtl/telemetry_rx.sv
// telemetry_rx: 8N1 UART receiver, 0xAA 0x55 header lock, three 12-bit telemetry fields.
// Latency: outputs and pkt_vld update one clock after the final payload byte's byte_rdy.
// Backpressure: none; the serial line cannot be stalled, results are held until the next packet.
// Optional feature: define TELEM_RX_TIMEOUT_EN to abandon packets stalled for TIMEOUT_CLKS idle clocks.
module telemetry_rx #(
  parameter int BAUD_DIV     = 2604,
  parameter int TIMEOUT_CLKS = 104160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic [11:0] batt_v,
  output logic [11:0] avg_curr,
  output logic [11:0] avg_torque,
  output logic        pkt_vld,
  output logic        pkt_err
);

  localparam int CNT_W = $clog2(BAUD_DIV + 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(BAUD_DIV / 2);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(BAUD_DIV);

  localparam logic [1:0] B_IDLE  = 2'd0;
  localparam logic [1:0] B_START = 2'd1;
  localparam logic [1:0] B_DATA  = 2'd2;
  localparam logic [1:0] B_STOP  = 2'd3;

  localparam logic [1:0] P_HUNT_AA = 2'd0;
  localparam logic [1:0] P_HUNT_55 = 2'd1;
  localparam logic [1:0] P_PAYLOAD = 2'd2;

  logic             rx_s1, rx_s2, rx_d;
  logic             start_edge;
  logic [1:0]       bit_st;
  logic [CNT_W-1:0] bit_cnt;
  logic             tick;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             byte_rdy;
  logic             frm_err;
  logic [7:0]       byte_dat;

  logic [1:0]       pkt_st;
  logic [2:0]       idx;
  logic [3:0]       sh_batt_hi, sh_curr_hi, sh_torq_hi;
  logic [7:0]       sh_batt_lo, sh_curr_lo;
  logic             hi_bad;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection; all idle high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign start_edge = rx_d & ~rx_s2;
  // Counter is loaded with N and the sample is taken on the edge where it reads 1, i.e. N clocks after load.
  assign tick       = (bit_cnt == CNT_W'(1));

  // Bit FSM: half-bit wait to mid start bit, then full-bit spaced samples for data and stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_st   <= B_IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      byte_rdy <= 1'b0;
      frm_err  <= 1'b0;
      byte_dat <= '0;
    end else begin
      byte_rdy <= 1'b0;
      frm_err  <= 1'b0;
      case (bit_st)
        B_IDLE: begin
          if (start_edge) begin
            bit_cnt <= HALF_BIT;
            bit_st  <= B_START;
          end
        end
        B_START: begin
          if (tick) begin
            if (rx_s2) begin
              bit_st <= B_IDLE;  // false start, no error
            end else begin
              bit_cnt <= FULL_BIT;
              bit_idx <= '0;
              bit_st  <= B_DATA;
            end
          end else begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end
        end
        B_DATA: begin
          if (tick) begin
            shreg   <= {rx_s2, shreg[7:1]};
            bit_cnt <= FULL_BIT;
            if (bit_idx == 3'd7) bit_st <= B_STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end
        end
        default: begin
          if (tick) begin
            if (rx_s2) begin
              byte_rdy <= 1'b1;
              byte_dat <= shreg;
            end else begin
              frm_err  <= 1'b1;
            end
            bit_st <= B_IDLE;
          end else begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Even payload indices are hi bytes; only their low nibble may be non-zero.
  assign hi_bad = ~idx[0] & (byte_dat[7:4] != 4'd0);

`ifdef TELEM_RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  assign tmo_hit = (pkt_st != P_HUNT_AA) && (bit_st == B_IDLE) && !start_edge &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CLKS - 1));

  // Idle-time counter while a packet is open; any start edge or return to hunting clears it.
  always_ff @(posedge clk) begin
    if (rst || pkt_st == P_HUNT_AA || tmo_hit || (bit_st == B_IDLE && start_edge)) begin
      tmo_cnt <= '0;
    end else if (bit_st == B_IDLE) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end
`endif

  // Packet FSM: header hunt, payload capture into shadows, single-clock commit of all three fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_st     <= P_HUNT_AA;
      idx        <= '0;
      sh_batt_hi <= '0;
      sh_batt_lo <= '0;
      sh_curr_hi <= '0;
      sh_curr_lo <= '0;
      sh_torq_hi <= '0;
      batt_v     <= '0;
      avg_curr   <= '0;
      avg_torque <= '0;
      pkt_vld    <= 1'b0;
      pkt_err    <= 1'b0;
    end else begin
      pkt_vld <= 1'b0;
      pkt_err <= 1'b0;
      case (pkt_st)
        P_HUNT_AA: begin
          if (byte_rdy && byte_dat == 8'hAA) pkt_st <= P_HUNT_55;
        end
        P_HUNT_55: begin
          if (byte_rdy) begin
            if (byte_dat == 8'h55) begin
              pkt_st <= P_PAYLOAD;
              idx    <= '0;
            end else if (byte_dat != 8'hAA) begin
              pkt_st <= P_HUNT_AA;
            end
          end
        end
        default: begin
          if (frm_err || (byte_rdy && hi_bad)) begin
            pkt_err <= 1'b1;
            pkt_st  <= P_HUNT_AA;
            idx     <= '0;
          end else if (byte_rdy) begin
            case (idx)
              3'd0:    sh_batt_hi <= byte_dat[3:0];
              3'd1:    sh_batt_lo <= byte_dat;
              3'd2:    sh_curr_hi <= byte_dat[3:0];
              3'd3:    sh_curr_lo <= byte_dat;
              3'd4:    sh_torq_hi <= byte_dat[3:0];
              default: ;
            endcase
            if (idx == 3'd5) begin
              batt_v     <= {sh_batt_hi, sh_batt_lo};
              avg_curr   <= {sh_curr_hi, sh_curr_lo};
              avg_torque <= {sh_torq_hi, byte_dat};
              pkt_vld    <= 1'b1;
              pkt_st     <= P_HUNT_AA;
              idx        <= '0;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
      endcase
`ifdef TELEM_RX_TIMEOUT_EN
      // A stall abandons the open packet; cannot coincide with a byte event.
      if (tmo_hit && !byte_rdy && !frm_err) begin
        pkt_err <= 1'b1;
        pkt_st  <= P_HUNT_AA;
        idx     <= '0;
      end
`endif
    end
  end

endmodule
